pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one parameter FLUSH_CYCLES, default 1, range 1..7: number of cycles IF_ID and ID_EX are flushed after a taken branch.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- id_reg1  in  3  source register 1 of instruction in ID
- id_reg2  in  3  source register 2 of instruction in ID
- id_use1  in  1  ID instruction reads id_reg1
- id_use2  in  1  ID instruction reads id_reg2
- ex_regD  in  3  destination register in EX (ID_EX regD output)
- ex_read_mem  in  1  EX instruction is a load
- ex_write_reg  in  1  EX instruction writes the register file
- branch_taken  in  1  branch resolved taken in EX, 1-cycle pulse
- mem_ready  in  1  data memory completes the access this cycle
- mem_req  in  1  MEM stage has an outstanding data-memory access
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF_ID contents
- if_id_flush  out  1  load NOP into IF_ID
- id_ex_stall  out  1  hold ID_EX contents
- id_ex_bubble  out  1  load NOP (all write/read enables 0) into ID_EX
- stall_cnt  out  16  saturating count of cycles with pc_stall=1
- flush_cnt  out  16  saturating count of taken-branch events

Function
REQ-004 The block SHALL implement FSM states RUN, FLUSH, MEM_WAIT; outputs SHALL be combinational from state and current inputs (same-cycle response).
REQ-005 The hazard signal SHALL be: ex_read_mem & ex_write_reg & ((id_use1 & id_reg1==ex_regD) | (id_use2 & id_reg2==ex_regD)); register 0 gets no special treatment.
REQ-006 In RUN, the priority SHALL be mem_req&!mem_ready > branch_taken > hazard > none.
REQ-007 RUN with mem_req&!mem_ready: pc_stall=if_id_stall=id_ex_stall=1; next state MEM_WAIT.
REQ-008 MEM_WAIT: pc_stall=if_id_stall=id_ex_stall=1 while mem_ready=0; on mem_ready=1 all outputs 0 that cycle and next state RUN.
REQ-009 branch_taken in MEM_WAIT SHALL be latched into a pending bit and acted on in the cycle the block returns to RUN, as if it arrived then.
REQ-010 RUN with branch_taken (or pending bit): if_id_flush=id_ex_bubble=1, no stalls; load flush counter with FLUSH_CYCLES-1; next state FLUSH if FLUSH_CYCLES>1, else RUN; pending bit cleared.
REQ-011 FLUSH: if_id_flush=id_ex_bubble=1; counter decrements; on counter==0 that cycle is the last flush cycle, next state RUN.
REQ-012 A branch_taken arriving in FLUSH SHALL reload the counter with FLUSH_CYCLES-1 and count as a new flush event.
REQ-013 Hazard in FLUSH SHALL be ignored; flush dominates.
REQ-014 RUN with hazard only: pc_stall=if_id_stall=id_ex_bubble=1, id_ex_stall=0, state stays RUN; one bubble per cycle the hazard persists.
REQ-015 id_ex_stall and id_ex_bubble SHALL never both be 1; if_id_stall and if_id_flush SHALL never both be 1.
REQ-016 stall_cnt SHALL increment every cycle pc_stall=1, saturating at 16'hFFFF; flush_cnt SHALL increment on each accepted branch event, saturating at 16'hFFFF.

Reset
REQ-017 While reset=1: state RUN, flush counter 0, pending bit 0, stall_cnt=flush_cnt=0, if_id_flush=id_ex_bubble=1, all stall outputs 0.
REQ-018 Reset asserted in FLUSH or MEM_WAIT SHALL abort the sequence; the first cycle after reset is RUN with no pending branch.

Structure
REQ-019 A shared package SHALL hold the state enum (ctrl_state_t) and a REG_ADDR_W=3 constant.
REQ-020 The hazard compare SHALL be a sub-module hazard_detect (purely combinational); counters and FSM live in pipeline_ctrl.

Verification
REQ-021 ex_read_mem=1, ex_write_reg=1, ex_regD=3, id_use1=1, id_reg1=3 in RUN -> pc_stall=if_id_stall=id_ex_bubble=1 same cycle; stall_cnt 0->1.
REQ-022 FLUSH_CYCLES=2, branch_taken pulse -> if_id_flush=id_ex_bubble=1 for exactly 2 cycles; flush_cnt=1; then RUN.
REQ-023 mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all three stalls high 3 cycles, low on ready cycle; stall_cnt=3.
REQ-024 branch_taken during MEM_WAIT -> no flush while waiting; flush starts on the mem_ready cycle; flush_cnt=1.
REQ-025 Reset asserted during FLUSH -> next cycle after reset shows RUN outputs, all counters 0.
REQ-026 Force stall_cnt to 16'hFFFE and stall 3 more cycles -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package pipeline_ctrl_pkg;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline status inputs and stall/flush controls exchanged with the controller.
interface pipeline_ctrl_if;
    import pipeline_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] id_reg1;
    logic [REG_ADDR_W-1:0] id_reg2;
    logic                  id_use1;
    logic                  id_use2;
    logic [REG_ADDR_W-1:0] ex_regD;
    logic                  ex_read_mem;
    logic                  ex_write_reg;
    logic                  branch_taken;
    logic                  mem_ready;
    logic                  mem_req;
    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  if_id_flush;
    logic                  id_ex_stall;
    logic                  id_ex_bubble;
    logic [15:0]           stall_cnt;
    logic [15:0]           flush_cnt;

    // The pipeline datapath drives status and consumes controls.
    modport master (
        output id_reg1, id_reg2, id_use1, id_use2, ex_regD, ex_read_mem,
               ex_write_reg, branch_taken, mem_ready, mem_req,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_reg1, id_reg2, id_use1, id_use2, ex_regD, ex_read_mem,
               ex_write_reg, branch_taken, mem_ready, mem_req,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_hazard.sv
// Load-use hazard compare between the ID sources and the EX load destination.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] reg1_i,
    input  logic [REG_ADDR_W-1:0] reg2_i,
    input  logic                  use1_i,
    input  logic                  use2_i,
    input  logic [REG_ADDR_W-1:0] ex_regD_i,
    input  logic                  ex_read_mem_i,
    input  logic                  ex_write_reg_i,
    output logic                  hazard_o
);
    // Register 0 is compared like any other register.
    assign hazard_o = ex_read_mem_i & ex_write_reg_i &
                      ((use1_i & (reg1_i == ex_regD_i)) |
                       (use2_i & (reg2_i == ex_regD_i)));
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: RUN/FLUSH/MEM_WAIT FSM with event counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    pipeline_ctrl_if.slave   bus
);
    localparam logic [2:0] FC_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI   = (FLUSH_CYCLES > 1);

    ctrl_state_t state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic        pend_q, pend_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic hazard;
    logic flush_evt;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble;

    hazard_detect u_hazard (
        .reg1_i        (bus.id_reg1),
        .reg2_i        (bus.id_reg2),
        .use1_i        (bus.id_use1),
        .use2_i        (bus.id_use2),
        .ex_regD_i     (bus.ex_regD),
        .ex_read_mem_i (bus.ex_read_mem),
        .ex_write_reg_i(bus.ex_write_reg),
        .hazard_o      (hazard)
    );

    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        pend_d       = pend_q;
        flush_evt    = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_bubble = 1'b0;

        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.mem_req && !bus.mem_ready) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_stall = 1'b1;
                        // A branch losing to the memory stall is kept, not dropped.
                        pend_d      = pend_q | bus.branch_taken;
                        state_d     = MEM_WAIT;
                    end else if (bus.branch_taken || pend_q) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        fcnt_d       = FC_LOAD;
                        pend_d       = 1'b0;
                        flush_evt    = 1'b1;
                        state_d      = MULTI ? FLUSH : RUN;
                    end else if (hazard) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (bus.branch_taken) begin
                        fcnt_d    = FC_LOAD;
                        flush_evt = 1'b1;
                        state_d   = MULTI ? FLUSH : RUN;
                    end else begin
                        // The branch cycle in RUN is the first flush cycle, so
                        // the last FLUSH cycle is the one that decrements to 0.
                        fcnt_d = fcnt_q - 3'd1;
                        if (fcnt_d == 3'd0)
                            state_d = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (!bus.mem_ready) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_stall = 1'b1;
                        pend_d      = pend_q | bus.branch_taken;
                    end else if (pend_q || bus.branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        fcnt_d       = FC_LOAD;
                        pend_d       = 1'b0;
                        flush_evt    = 1'b1;
                        state_d      = MULTI ? FLUSH : RUN;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (pc_stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        flush_cnt_d = flush_cnt_q;
        if (flush_evt && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            fcnt_q      <= 3'd0;
            pend_q      <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_stall     = pc_stall;
    assign bus.if_id_stall  = if_id_stall;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_stall  = id_ex_stall;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl with FLUSH_CYCLES=2.
module tb_pipeline_ctrl;
    logic clk;
    logic reset;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [2:0] reg1;
        logic [2:0] reg2;
        logic       use1;
        logic       use2;
        logic [2:0] regD;
        logic       rmem;
        logic       wreg;
        logic       br;
        logic       rdy;
        logic       mreq;
    } in_t;

    typedef struct {
        in_t        in;
        logic [4:0] exp;
        string      name;
    } vec_t;

    // Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble}
    localparam logic [4:0] E_NONE = 5'b00000;
    localparam logic [4:0] E_HAZ  = 5'b11001;
    localparam logic [4:0] E_FL   = 5'b00101;
    localparam logic [4:0] E_MEM  = 5'b11010;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [15:0] m_stall = 16'd0;
    logic [4:0]  exp_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic in_t hz(input logic [2:0] r1, input logic [2:0] r2,
                               input logic u1, input logic u2, input logic [2:0] rd,
                               input logic rm, input logic wr);
        in_t i;
        i = '0;
        i.reg1 = r1; i.reg2 = r2; i.use1 = u1; i.use2 = u2;
        i.regD = rd; i.rmem = rm; i.wreg = wr;
        return i;
    endfunction

    function automatic in_t ctl(input logic rst, input logic br, input logic mreq, input logic rdy);
        in_t i;
        i = '0;
        i.rst = rst; i.br = br; i.mreq = mreq; i.rdy = rdy;
        return i;
    endfunction

    // One cycle: drive after negedge, check outputs mid-cycle, check stall_cnt after the edge.
    task automatic step(input string name, input in_t i, input logic [4:0] e);
        logic [4:0] got, want;
        @(negedge clk);
        reset            = i.rst;
        bus.id_reg1      = i.reg1;
        bus.id_reg2      = i.reg2;
        bus.id_use1      = i.use1;
        bus.id_use2      = i.use2;
        bus.ex_regD      = i.regD;
        bus.ex_read_mem  = i.rmem;
        bus.ex_write_reg = i.wreg;
        bus.branch_taken = i.br;
        bus.mem_ready    = i.rdy;
        bus.mem_req      = i.mreq;
        exp_q.push_back(e);
        #2;
        got  = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall, bus.id_ex_bubble};
        want = exp_q.pop_front();
        chk({name, "/outs"}, {11'd0, got}, {11'd0, want});
        @(posedge clk);
        if (i.rst) m_stall = 16'd0;
        else if (want[4] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        #1;
        chk({name, "/stall_cnt"}, bus.stall_cnt, m_stall);
    endtask

    vec_t tbl[9];
    in_t  t;

    initial begin
        reset = 1'b1;
        bus.id_reg1 = '0; bus.id_reg2 = '0; bus.id_use1 = 0; bus.id_use2 = 0;
        bus.ex_regD = '0; bus.ex_read_mem = 0; bus.ex_write_reg = 0;
        bus.branch_taken = 0; bus.mem_ready = 0; bus.mem_req = 0;

        tbl[0] = '{hz(3'd0, 3'd0, 0, 0, 3'd0, 0, 0), E_NONE, "idle"};
        tbl[1] = '{hz(3'd3, 3'd5, 1, 0, 3'd3, 1, 1), E_HAZ,  "haz_reg1"};
        tbl[2] = '{hz(3'd1, 3'd6, 0, 1, 3'd6, 1, 1), E_HAZ,  "haz_reg2"};
        tbl[3] = '{hz(3'd4, 3'd4, 0, 0, 3'd4, 1, 1), E_NONE, "no_use"};
        tbl[4] = '{hz(3'd2, 3'd0, 1, 0, 3'd2, 0, 1), E_NONE, "not_load"};
        tbl[5] = '{hz(3'd2, 3'd0, 1, 0, 3'd2, 1, 0), E_NONE, "no_wreg"};
        tbl[6] = '{hz(3'd0, 3'd7, 1, 1, 3'd0, 1, 1), E_HAZ,  "haz_r0"};
        tbl[7] = '{hz(3'd1, 3'd2, 1, 1, 3'd5, 1, 1), E_NONE, "mismatch"};
        t = hz(3'd7, 3'd0, 1, 0, 3'd7, 1, 1); t.mreq = 1; t.rdy = 1;
        tbl[8] = '{t, E_HAZ, "haz_mem_ready"};

        // reset state
        step("reset", ctl(1, 0, 0, 0), E_FL);
        chk("reset/flush_cnt", bus.flush_cnt, 16'd0);

        for (int k = 0; k < 9; k++) step(tbl[k].name, tbl[k].in, tbl[k].exp);

        // two-cycle flush, hazard ignored in FLUSH
        step("br", ctl(0, 1, 0, 0), E_FL);
        step("fl_haz", hz(3'd3, 3'd0, 1, 0, 3'd3, 1, 1), E_FL);
        step("fl_done", ctl(0, 0, 0, 0), E_NONE);
        chk("br/flush_cnt", bus.flush_cnt, 16'd1);

        // memory wait
        for (int k = 0; k < 3; k++) step("mw", ctl(0, 0, 1, 0), E_MEM);
        step("mw_ready", ctl(0, 0, 1, 1), E_NONE);
        step("mw_after", ctl(0, 0, 0, 0), E_NONE);

        // branch during MEM_WAIT deferred to the ready cycle
        step("bm_wait", ctl(0, 0, 1, 0), E_MEM);
        step("bm_br", ctl(0, 1, 1, 0), E_MEM);
        step("bm_wait2", ctl(0, 0, 1, 0), E_MEM);
        step("bm_ready", ctl(0, 0, 1, 1), E_FL);
        step("bm_fl", ctl(0, 0, 0, 0), E_FL);
        step("bm_done", ctl(0, 0, 0, 0), E_NONE);
        chk("bm/flush_cnt", bus.flush_cnt, 16'd2);

        // branch inside FLUSH reloads the counter
        step("rl_br", ctl(0, 1, 0, 0), E_FL);
        step("rl_br2", ctl(0, 1, 0, 0), E_FL);
        step("rl_fl", ctl(0, 0, 0, 0), E_FL);
        step("rl_done", ctl(0, 0, 0, 0), E_NONE);
        chk("rl/flush_cnt", bus.flush_cnt, 16'd4);

        // reset during FLUSH aborts the sequence
        step("rf_br", ctl(0, 1, 0, 0), E_FL);
        step("rf_rst", ctl(1, 0, 0, 0), E_FL);
        chk("rf/flush_cnt", bus.flush_cnt, 16'd0);
        step("rf_run", ctl(0, 0, 0, 0), E_NONE);

        // pending branch cleared by reset during MEM_WAIT
        step("rm_br", ctl(0, 1, 1, 0), E_MEM);
        step("rm_rst", ctl(1, 0, 0, 0), E_FL);
        step("rm_run", ctl(0, 0, 0, 0), E_NONE);
        chk("rm/flush_cnt", bus.flush_cnt, 16'd0);

        // stall counter saturation
        @(negedge clk);
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        m_stall = 16'hFFFE;
        for (int k = 0; k < 3; k++) step("sat", hz(3'd3, 3'd0, 1, 0, 3'd3, 1, 1), E_HAZ);
        chk("sat/final", bus.stall_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
